// File: rtl/wakeup_scoreboard_pkg.sv
// Shared constants for the wakeup scoreboard: RS entry type codes, latency width and pattern helper.
package wakeup_scoreboard_pkg;

    localparam int unsigned MAX_LATENCY = 4;
    localparam int unsigned RS_ENT_SEL  = 3;

    typedef logic [MAX_LATENCY-1:0] lat_t;
    typedef logic [RS_ENT_SEL-1:0]  rs_ent_t;

    localparam rs_ent_t RS_ENT_ALU    = 3'd1;
    localparam rs_ent_t RS_ENT_BRANCH = 3'd2;
    localparam rs_ent_t RS_ENT_MUL    = 3'd3;
    localparam rs_ent_t RS_ENT_LDST   = 3'd4;

    // Per-register readiness state held by each scoreboard entry
    typedef struct packed {
        logic match;
        lat_t delay;
        lat_t shift;
    } sb_state_t;

    localparam sb_state_t SB_READY = '1;

    // Producer latency pattern, MSB-aligned
    function automatic lat_t lat_pat(input rs_ent_t ent_type);
        lat_t pat;
        pat = '0;
        case (ent_type)
            RS_ENT_ALU, RS_ENT_BRANCH: pat = '1;
            RS_ENT_MUL:                pat[MAX_LATENCY-1 -: 2] = 2'b11;
            RS_ENT_LDST:               pat[MAX_LATENCY-1] = 1'b1;
            default:                   pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/wakeup_scoreboard_if.sv
// Dispatch/lookup/broadcast bundle of the wakeup scoreboard.
// Recovery ports exist only when SB_RECOVERY_EN is defined.
interface wakeup_scoreboard_if
    import wakeup_scoreboard_pkg::*;
#(
    parameter int unsigned PHY_REG_NUM = 64,
    parameter int unsigned PHY_REG_SEL = 6,
    parameter int unsigned DISPATCH_W  = 2,
    parameter int unsigned BCAST_W     = 3
) ();

    logic [DISPATCH_W-1:0]                 disp_valid;
    logic [DISPATCH_W-1:0]                 disp_wr_reg;
    logic [DISPATCH_W*RS_ENT_SEL-1:0]      disp_type;
    logic [DISPATCH_W*PHY_REG_SEL-1:0]     disp_dst;
    logic [2*DISPATCH_W*PHY_REG_SEL-1:0]   disp_src;
    logic [2*DISPATCH_W-1:0]               src_match;
    logic [2*DISPATCH_W*MAX_LATENCY-1:0]   src_shift;
    logic [2*DISPATCH_W*MAX_LATENCY-1:0]   src_delay;
    logic [BCAST_W-1:0]                    bc_valid;
    logic [BCAST_W*PHY_REG_SEL-1:0]        bc_tag;

`ifdef SB_RECOVERY_EN
    logic                                  flush;
    logic [PHY_REG_NUM-1:0]                flush_mask;

    modport master (
        output disp_valid, disp_wr_reg, disp_type, disp_dst, disp_src,
        output bc_valid, bc_tag, flush, flush_mask,
        input  src_match, src_shift, src_delay
    );
    modport slave (
        input  disp_valid, disp_wr_reg, disp_type, disp_dst, disp_src,
        input  bc_valid, bc_tag, flush, flush_mask,
        output src_match, src_shift, src_delay
    );
`else
    modport master (
        output disp_valid, disp_wr_reg, disp_type, disp_dst, disp_src,
        output bc_valid, bc_tag,
        input  src_match, src_shift, src_delay
    );
    modport slave (
        input  disp_valid, disp_wr_reg, disp_type, disp_dst, disp_src,
        input  bc_valid, bc_tag,
        output src_match, src_shift, src_delay
    );
`endif

endinterface

// File: rtl/wakeup_scoreboard_sb_entry.sv
// One physical register's match/delay/shift_r state with prioritised update.
// Flush input present only when SB_RECOVERY_EN is defined.
module sb_entry
    import wakeup_scoreboard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  lat_t      wr_delay,
    input  logic      bc_hit,
`ifdef SB_RECOVERY_EN
    input  logic      flush_hit,
`endif
    output sb_state_t state
);

    sb_state_t state_q;
    sb_state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SB_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Newest allocation beats a same-cycle broadcast; waiting wakeups fill from the MSB
    always_comb begin
        state_d = state_q;
`ifdef SB_RECOVERY_EN
        if (flush_hit) begin
            state_d = SB_READY;
        end else
`endif
        if (wr_en) begin
            state_d.match = 1'b0;
            state_d.delay = wr_delay;
            state_d.shift = '0;
        end else if (bc_hit) begin
            state_d.match = 1'b1;
            state_d.shift = state_q.delay;
        end else if (state_q.match && !state_q.shift[0]) begin
            state_d.shift = {state_q.shift[MAX_LATENCY-1], state_q.shift[MAX_LATENCY-1:1]};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/wakeup_scoreboard.sv
// N-wide dispatch readiness scoreboard: write/broadcast decode, entry array, forwarding lookup.
// Define SB_RECOVERY_EN to add flush-based misprediction recovery.
module wakeup_scoreboard
    import wakeup_scoreboard_pkg::*;
#(
    parameter int unsigned PHY_REG_NUM = 64,
    parameter int unsigned PHY_REG_SEL = 6,
    parameter int unsigned DISPATCH_W  = 2,
    parameter int unsigned BCAST_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    wakeup_scoreboard_if.slave  sb
);

    logic [DISPATCH_W-1:0]  slot_fwd;
    logic [DISPATCH_W-1:0]  slot_wr;
    logic [PHY_REG_NUM-1:1] wr_en;
    logic [PHY_REG_NUM-1:1] bc_hit;
    lat_t                   wr_delay [PHY_REG_NUM-1:1];
    sb_state_t              ent      [PHY_REG_NUM-1:1];

    assign slot_fwd = sb.disp_valid & sb.disp_wr_reg;

`ifdef SB_RECOVERY_EN
    logic [PHY_REG_NUM-1:1] flush_hit;

    assign slot_wr   = slot_fwd & ~{DISPATCH_W{sb.flush}};
    assign flush_hit = {(PHY_REG_NUM-1){sb.flush}} & sb.flush_mask[PHY_REG_NUM-1:1];
`else
    assign slot_wr   = slot_fwd;
`endif

    // Per-tag write and broadcast decode; the highest writing slot supplies the delay
    always_comb begin
        wr_en  = '0;
        bc_hit = '0;
        for (int t = 1; t < int'(PHY_REG_NUM); t++) begin
            wr_delay[t] = '0;
            for (int s = 0; s < int'(DISPATCH_W); s++) begin
                if (slot_wr[s] && sb.disp_dst[s*PHY_REG_SEL +: PHY_REG_SEL] == PHY_REG_SEL'(t)) begin
                    wr_en[t]    = 1'b1;
                    wr_delay[t] = lat_pat(sb.disp_type[s*RS_ENT_SEL +: RS_ENT_SEL]);
                end
            end
            for (int b = 0; b < int'(BCAST_W); b++) begin
                if (sb.bc_valid[b] && sb.bc_tag[b*PHY_REG_SEL +: PHY_REG_SEL] == PHY_REG_SEL'(t)) begin
                    bc_hit[t] = 1'b1;
                end
            end
        end
    end

    for (genvar t = 1; t < PHY_REG_NUM; t++) begin : g_ent
        sb_entry u_entry (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr_en[t]),
            .wr_delay  (wr_delay[t]),
            .bc_hit    (bc_hit[t]),
`ifdef SB_RECOVERY_EN
            .flush_hit (flush_hit[t]),
`endif
            .state     (ent[t])
        );
    end

    // Source lookup: stored state, then broadcast bypass, then youngest older-slot forwarding
    always_comb begin
        logic [PHY_REG_SEL-1:0] src;
        logic                   m;
        lat_t                   sh;
        lat_t                   dl;
        sb.src_match = '0;
        sb.src_shift = '0;
        sb.src_delay = '0;
        for (int s = 0; s < int'(DISPATCH_W); s++) begin
            for (int k = 0; k < 2; k++) begin
                src = sb.disp_src[(2*s+k)*PHY_REG_SEL +: PHY_REG_SEL];
                m   = 1'b1;
                sh  = '1;
                dl  = '1;
                for (int t = 1; t < int'(PHY_REG_NUM); t++) begin
                    if (src == PHY_REG_SEL'(t)) begin
                        m  = ent[t].match | bc_hit[t];
                        sh = bc_hit[t] ? ent[t].delay : ent[t].shift;
                        dl = ent[t].delay;
                    end
                end
                for (int j = 0; j < s; j++) begin
                    if (slot_fwd[j] && src != '0 &&
                        sb.disp_dst[j*PHY_REG_SEL +: PHY_REG_SEL] == src) begin
                        m  = 1'b0;
                        sh = '0;
                        dl = lat_pat(sb.disp_type[j*RS_ENT_SEL +: RS_ENT_SEL]);
                    end
                end
                sb.src_match[2*s+k]                         = m;
                sb.src_shift[(2*s+k)*MAX_LATENCY +: MAX_LATENCY] = sh;
                sb.src_delay[(2*s+k)*MAX_LATENCY +: MAX_LATENCY] = dl;
            end
        end
    end

endmodule

// File: tb/tb_wakeup_scoreboard.sv
// Scoreboard-queue bench for wakeup_scoreboard: directed scenarios plus a randomised run against a reference model.
module tb_wakeup_scoreboard;
    import wakeup_scoreboard_pkg::*;

    localparam int unsigned NREG = 64;
    localparam int unsigned SEL  = 6;
    localparam int unsigned DW   = 4;
    localparam int unsigned BW   = 4;
    localparam int unsigned NOP  = 2 * DW;
    localparam int unsigned ML   = MAX_LATENCY;

    typedef struct packed {
        logic [3:0] op;
        logic       m;
        lat_t       s;
        lat_t       d;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    errors = 0;
    string tname;
    exp_t  exp_q[$];

    logic mm [NREG];
    lat_t md [NREG];
    lat_t ms [NREG];

    wakeup_scoreboard_if #(.PHY_REG_NUM(NREG), .PHY_REG_SEL(SEL), .DISPATCH_W(DW), .BCAST_W(BW)) sb_if ();

    wakeup_scoreboard #(.PHY_REG_NUM(NREG), .PHY_REG_SEL(SEL), .DISPATCH_W(DW), .BCAST_W(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    function automatic lat_t ref_lat(input rs_ent_t ty);
        case (ty)
            RS_ENT_ALU, RS_ENT_BRANCH: return 4'b1111;
            RS_ENT_MUL:                return 4'b1100;
            RS_ENT_LDST:               return 4'b1000;
            default:                   return 4'b0000;
        endcase
    endfunction

    task automatic idle();
        sb_if.disp_valid  = '0;
        sb_if.disp_wr_reg = '0;
        sb_if.disp_type   = '0;
        sb_if.disp_dst    = '0;
        sb_if.disp_src    = '0;
        sb_if.bc_valid    = '0;
        sb_if.bc_tag      = '0;
`ifdef SB_RECOVERY_EN
        sb_if.flush       = 1'b0;
        sb_if.flush_mask  = '0;
`endif
    endtask

    task automatic set_slot(input int s, input bit v, input bit w, input rs_ent_t ty,
                            input int dst, input int s0, input int s1);
        sb_if.disp_valid[s]                        = v;
        sb_if.disp_wr_reg[s]                       = w;
        sb_if.disp_type[s*RS_ENT_SEL +: RS_ENT_SEL] = ty;
        sb_if.disp_dst[s*SEL +: SEL]               = SEL'(dst);
        sb_if.disp_src[(2*s)*SEL +: SEL]           = SEL'(s0);
        sb_if.disp_src[(2*s+1)*SEL +: SEL]         = SEL'(s1);
    endtask

    task automatic set_bc(input int b, input int tag);
        sb_if.bc_valid[b]            = 1'b1;
        sb_if.bc_tag[b*SEL +: SEL]   = SEL'(tag);
    endtask

    task automatic expect_op(input int op, input logic m, input lat_t s, input lat_t d);
        exp_t e;
        e.op = 4'(op);
        e.m  = m;
        e.s  = s;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    function automatic bit bc_hits(input int tag);
        for (int b = 0; b < int'(BW); b++)
            if (sb_if.bc_valid[b] && int'(sb_if.bc_tag[b*SEL +: SEL]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    // Reference lookup: searches older slots youngest-first
    task automatic model_lookup(input int op);
        int   slot;
        int   src;
        logic m;
        lat_t s;
        lat_t d;
        slot = op / 2;
        src  = int'(sb_if.disp_src[op*SEL +: SEL]);
        if (src == 0) begin
            m = 1'b1; s = 4'b1111; d = 4'b1111;
        end else begin
            m = mm[src]; s = ms[src]; d = md[src];
            if (bc_hits(src)) begin
                m = 1'b1; s = md[src];
            end
            for (int j = slot - 1; j >= 0; j--) begin
                if (sb_if.disp_valid[j] && sb_if.disp_wr_reg[j] && int'(sb_if.disp_dst[j*SEL +: SEL]) == src) begin
                    m = 1'b0; s = 4'b0000; d = ref_lat(sb_if.disp_type[j*RS_ENT_SEL +: RS_ENT_SEL]);
                    break;
                end
            end
        end
        expect_op(op, m, s, d);
    endtask

    task automatic model_step();
        bit fl;
        bit wr;
        lat_t wd;
        fl = 1'b0;
`ifdef SB_RECOVERY_EN
        fl = sb_if.flush;
`endif
        if (reset) begin
            for (int t = 0; t < int'(NREG); t++) begin
                mm[t] = 1'b1; md[t] = 4'b1111; ms[t] = 4'b1111;
            end
            return;
        end
        for (int t = 1; t < int'(NREG); t++) begin
            wr = 1'b0;
            wd = 4'b0000;
            for (int s = int'(DW) - 1; s >= 0; s--) begin
                if (!fl && sb_if.disp_valid[s] && sb_if.disp_wr_reg[s] && int'(sb_if.disp_dst[s*SEL +: SEL]) == t) begin
                    wr = 1'b1; wd = ref_lat(sb_if.disp_type[s*RS_ENT_SEL +: RS_ENT_SEL]);
                    break;
                end
            end
`ifdef SB_RECOVERY_EN
            if (fl && sb_if.flush_mask[t]) begin
                mm[t] = 1'b1; md[t] = 4'b1111; ms[t] = 4'b1111;
                continue;
            end
`endif
            if (wr) begin
                mm[t] = 1'b0; md[t] = wd; ms[t] = 4'b0000;
            end else if (bc_hits(t)) begin
                mm[t] = 1'b1; ms[t] = md[t];
            end else if (mm[t] && !ms[t][0]) begin
                ms[t] = (ms[t] >> 1) | (ms[t] & 4'b1000);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [2*ML:0] got;
        tname = "reset";
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 5, 0);
        expect_op(0, 1'b1, 4'b1111, 4'b1111);
        expect_op(1, 1'b1, 4'b1111, 4'b1111);
        @(negedge clk);
        while (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
            checks++;
            if (got !== {e.m, e.s, e.d}) begin
                errors++;
                $display("FAIL %s op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, e.op,
                         got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
            end
        end
        tick();
    endtask

    task automatic test_mul_wakeup();
        exp_t e;
        logic [2*ML:0] got;
        lat_t seq [4] = '{4'b1100, 4'b1110, 4'b1111, 4'b1111};
        tname = "mul_wakeup";
        idle();
        set_slot(0, 1'b1, 1'b1, RS_ENT_MUL, 7, 0, 0);
        tick();
        for (int c = 0; c < 6; c++) begin
            idle();
            set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 7, 0);
            if (c == 0) expect_op(0, 1'b0, 4'b0000, 4'b1100);
            else if (c == 1) begin
                set_bc(0, 7);
                expect_op(0, 1'b1, 4'b1100, 4'b1100);
            end else expect_op(0, 1'b1, seq[c-2], 4'b1100);
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s c%0d op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, c, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask

    task automatic test_forward();
        exp_t e;
        logic [2*ML:0] got;
        tname = "forward";
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                set_slot(0, 1'b1, 1'b1, RS_ENT_LDST, 9, 9, 0);
                set_slot(1, 1'b1, 1'b0, RS_ENT_ALU, 0, 0, 9);
                set_slot(2, 1'b1, 1'b1, RS_ENT_ALU, 9, 0, 0);
                set_slot(3, 1'b1, 1'b0, RS_ENT_ALU, 0, 9, 0);
                expect_op(0, 1'b1, 4'b1111, 4'b1111);
                expect_op(2, 1'b1, 4'b1111, 4'b1111);
                expect_op(3, 1'b0, 4'b0000, 4'b1000);
                expect_op(6, 1'b0, 4'b0000, 4'b1111);
            end else begin
                set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 9, 0);
                expect_op(0, 1'b0, 4'b0000, 4'b1111);
            end
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s c%0d op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, c, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask

    task automatic test_tag0();
        exp_t e;
        logic [2*ML:0] got;
        tname = "tag0";
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                set_slot(0, 1'b1, 1'b1, RS_ENT_MUL, 0, 0, 0);
                set_slot(1, 1'b1, 1'b0, RS_ENT_ALU, 0, 0, 0);
                set_bc(0, 0);
                expect_op(2, 1'b1, 4'b1111, 4'b1111);
            end else begin
                set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 0, 0);
                expect_op(0, 1'b1, 4'b1111, 4'b1111);
            end
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s c%0d op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, c, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask

    // Dispatch beats same-cycle broadcast; multiple ports hitting one tag act once
    task automatic test_back_to_back();
        exp_t e;
        logic [2*ML:0] got;
        tname = "back_to_back";
        for (int c = 0; c < 6; c++) begin
            idle();
            case (c)
                0: begin
                    set_slot(0, 1'b1, 1'b1, RS_ENT_ALU, 12, 0, 0);
                    set_slot(1, 1'b1, 1'b1, RS_ENT_LDST, 30, 0, 0);
                    set_bc(0, 12);
                end
                1: begin
                    set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 12, 30);
                    expect_op(0, 1'b0, 4'b0000, 4'b1111);
                    expect_op(1, 1'b0, 4'b0000, 4'b1000);
                end
                2: begin
                    set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 12, 30);
                    set_bc(0, 12);
                    for (int b = 1; b < int'(BW); b++) set_bc(b, 30);
                    expect_op(0, 1'b1, 4'b1111, 4'b1111);
                    expect_op(1, 1'b1, 4'b1000, 4'b1000);
                end
                default: begin
                    set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 30, 0);
                    expect_op(0, 1'b1, (c == 3) ? 4'b1000 : (c == 4) ? 4'b1100 : 4'b1110, 4'b1000);
                end
            endcase
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s c%0d op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, c, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask

`ifdef SB_RECOVERY_EN
    task automatic test_flush();
        exp_t e;
        logic [2*ML:0] got;
        tname = "flush";
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                set_slot(0, 1'b1, 1'b1, RS_ENT_ALU, 20, 0, 0);
            end else if (c == 1) begin
                sb_if.flush          = 1'b1;
                sb_if.flush_mask[20] = 1'b1;
                set_slot(0, 1'b1, 1'b1, RS_ENT_MUL, 21, 0, 0);
                set_bc(0, 20);
            end else begin
                set_slot(0, 1'b0, 1'b0, RS_ENT_ALU, 0, 20, 21);
                expect_op(0, 1'b1, 4'b1111, 4'b1111);
                expect_op(1, 1'b1, 4'b1111, 4'b1111);
            end
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        exp_t e;
        logic [2*ML:0] got;
        bit skip;
        tname = "random";
        for (int c = 0; c < 10000; c++) begin
            idle();
            skip = 1'b0;
            for (int s = 0; s < int'(DW); s++) begin
                set_slot(s, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                         rs_ent_t'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            for (int b = 0; b < int'(BW); b++) begin
                if ($urandom_range(0, 1) == 1) set_bc(b, int'($urandom_range(0, 15)));
            end
`ifdef SB_RECOVERY_EN
            if ($urandom_range(0, 31) == 0) begin
                sb_if.flush      = 1'b1;
                sb_if.flush_mask = {$urandom, $urandom};
                skip             = 1'b1;
            end
`endif
            if (!skip) begin
                for (int op = 0; op < int'(NOP); op++) model_lookup(op);
            end
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {sb_if.src_match[e.op], sb_if.src_shift[e.op*ML +: ML], sb_if.src_delay[e.op*ML +: ML]};
                checks++;
                if (got !== {e.m, e.s, e.d}) begin
                    errors++;
                    $display("FAIL %s c%0d op%0d: got m/s/d=%b/%b/%b required %b/%b/%b", tname, c, e.op,
                             got[2*ML], got[2*ML-1 -: ML], got[ML-1:0], e.m, e.s, e.d);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_mul_wakeup();
        test_forward();
        test_tag0();
        test_back_to_back();
`ifdef SB_RECOVERY_EN
        test_flush();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
